modulo_ctrl_decodi: RTL and testbench

//  Sequencing controller for the Hamming(8,4) SECDED decode datapath.
//  - Accepts 8-bit codewords [p0,i3,i2,i1,c2,i0,c1,c0] over a valid/ready handshake.
//  - Computes the syndrome, corrects single-bit errors and flags double errors.
//  - Delivers 4-bit data [i3,i2,i1,i0] over a valid/ready handshake.
//  - Sits between the received-codeword source and the data consumer.

---
 rtl/modulo_ctrl_decodi.sv | 151 +++++++++++++++
 tb/tb_modulo_ctrl_decodi.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/modulo_ctrl_decodi.sv
// Hamming(8,4) SECDED decode sequencer: IDLE -> CALC -> CORR -> ENTREGA.
// Define DECODI_STATS_EN to build the saturating error counters.
module modulo_ctrl_decodi #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       datos_cod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       datos_out,
   output logic             err_simple,
   output logic             err_doble,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] cnt_corr,
   output logic [CNT_W-1:0] cnt_doble
);

   typedef enum logic [1:0] {IDLE, CALC, CORR, ENTREGA} state_t;

   state_t     r_state;
   logic [7:0] r_cod;
   logic [2:0] r_s;
   logic       r_p;
   logic [3:0] r_dat;
   logic       r_fs;
   logic       r_fd;
   logic       r_in_ready;
   logic       r_out_valid;
   logic [3:0] r_datos_out;
   logic       r_err_simple;
   logic       r_err_doble;

   logic [2:0] w_idx;
   logic [7:0] w_fix;
   logic       w_hs;

   always_comb begin
      w_idx = r_s - 3'd1;
      w_fix = r_cod ^ (8'd1 << w_idx);
      w_hs  = (r_state == ENTREGA) & r_out_valid & out_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cod        <= '0;
         r_s          <= '0;
         r_p          <= 1'b0;
         r_dat        <= '0;
         r_fs         <= 1'b0;
         r_fd         <= 1'b0;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_datos_out  <= '0;
         r_err_simple <= 1'b0;
         r_err_doble  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_cod      <= datos_cod;
                  r_in_ready <= 1'b0;
                  r_state    <= CALC;
               end
            end
            CALC: begin
               r_s[0]  <= r_cod[0] ^ r_cod[2] ^ r_cod[4] ^ r_cod[6];
               r_s[1]  <= r_cod[1] ^ r_cod[2] ^ r_cod[5] ^ r_cod[6];
               r_s[2]  <= r_cod[3] ^ r_cod[4] ^ r_cod[5] ^ r_cod[6];
               r_p     <= ^r_cod;
               r_state <= CORR;
            end
            CORR: begin
               // s=0 with p=1 means the error hit p0 itself
               unique case (1'b1)
                  (r_s == 3'd0): begin
                     r_dat <= {r_cod[6], r_cod[5], r_cod[4], r_cod[2]};
                     r_fs  <= r_p;
                     r_fd  <= 1'b0;
                  end
                  (r_s != 3'd0) && r_p: begin
                     r_dat <= {w_fix[6], w_fix[5], w_fix[4], w_fix[2]};
                     r_fs  <= 1'b1;
                     r_fd  <= 1'b0;
                  end
                  (r_s != 3'd0) && !r_p: begin
                     r_dat <= {r_cod[6], r_cod[5], r_cod[4], r_cod[2]};
                     r_fs  <= 1'b0;
                     r_fd  <= 1'b1;
                  end
               endcase
               r_state <= ENTREGA;
            end
            ENTREGA: begin
               if (!r_out_valid) begin
                  r_out_valid  <= 1'b1;
                  r_datos_out  <= r_dat;
                  r_err_simple <= r_fs;
                  r_err_doble  <= r_fd;
               end else if (out_ready) begin
                  r_out_valid  <= 1'b0;
                  r_err_simple <= 1'b0;
                  r_err_doble  <= 1'b0;
                  r_in_ready   <= 1'b1;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign datos_out  = r_datos_out;
   assign err_simple = r_err_simple;
   assign err_doble  = r_err_doble;

`ifdef DECODI_STATS_EN
   logic [CNT_W-1:0] r_cnt_corr;
   logic [CNT_W-1:0] r_cnt_doble;

   // clear wins over a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_corr  <= '0;
         r_cnt_doble <= '0;
      end else if (clr_cnt) begin
         r_cnt_corr  <= '0;
         r_cnt_doble <= '0;
      end else if (w_hs) begin
         if (r_err_simple && (r_cnt_corr != '1))
            r_cnt_corr <= r_cnt_corr + CNT_W'(1);
         if (r_err_doble && (r_cnt_doble != '1))
            r_cnt_doble <= r_cnt_doble + CNT_W'(1);
      end
   end

   assign cnt_corr  = r_cnt_corr;
   assign cnt_doble = r_cnt_doble;
`else
   logic w_unused;
   assign w_unused  = clr_cnt | w_hs;
   assign cnt_corr  = '0;
   assign cnt_doble = '0;
`endif

endmodule

// File: tb/tb_modulo_ctrl_decodi.sv
// Bench for modulo_ctrl_decodi: vector table plus handshake corner sequences.
module tb_modulo_ctrl_decodi;

   localparam int CNT_W = 2;
   localparam int CMAX  = 3;
`ifdef DECODI_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic [7:0] cod;
      logic [3:0] dat;
      logic       fs;
      logic       fd;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       datos_cod = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [3:0]       datos_out;
   logic             err_simple;
   logic             err_doble;
   logic             clr_cnt = 1'b0;
   logic [CNT_W-1:0] cnt_corr;
   logic [CNT_W-1:0] cnt_doble;

   int   n_pass = 0;
   int   n_tot  = 0;
   int   exp_corr = 0;
   int   exp_doble = 0;
   vec_t sb[$];
   vec_t tbl[10];

   modulo_ctrl_decodi #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .datos_cod  (datos_cod),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .datos_out  (datos_out),
      .err_simple (err_simple),
      .err_doble  (err_doble),
      .clr_cnt    (clr_cnt),
      .cnt_corr   (cnt_corr),
      .cnt_doble  (cnt_doble)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic xfer(input vec_t v, input int hold,
                       input bit pulse, input bit clr);
      int   lat;
      vec_t e;
      lat = 0;
      while (!in_ready && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk("in_ready_idle", in_ready, 1);
      datos_cod = v.cod;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back(v);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk("latency", lat, 3);
      for (int i = 0; i < hold; i++) begin
         if (pulse && i == 3) begin
            datos_cod = 8'h3F;
            in_valid  = 1'b1;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("bp_valid", out_valid, 1);
         chk("bp_data", datos_out, v.dat);
         chk("bp_in_ready", in_ready, 0);
      end
      e = sb.pop_front();
      chk("datos_out", datos_out, e.dat);
      chk("err_simple", err_simple, e.fs);
      chk("err_doble", err_doble, e.fd);
      out_ready = 1'b1;
      clr_cnt   = clr;
      @(posedge clk); #1;
      out_ready = 1'b0;
      clr_cnt   = 1'b0;
      if (STATS) begin
         if (clr) begin
            exp_corr  = 0;
            exp_doble = 0;
         end else begin
            if (e.fs && exp_corr < CMAX) exp_corr++;
            if (e.fd && exp_doble < CMAX) exp_doble++;
         end
      end
      chk("valid_drop", out_valid, 0);
      chk("simple_drop", err_simple, 0);
      chk("doble_drop", err_doble, 0);
      chk("in_ready_back", in_ready, 1);
      chk("cnt_corr", cnt_corr, exp_corr);
      chk("cnt_doble", cnt_doble, exp_doble);
   endtask

   initial begin
      tbl[0] = '{8'h55, 4'hB, 1'b0, 1'b0};
      tbl[1] = '{8'h45, 4'hB, 1'b1, 1'b0};
      tbl[2] = '{8'hD5, 4'hB, 1'b1, 1'b0};
      tbl[3] = '{8'h56, 4'hB, 1'b0, 1'b1};
      tbl[4] = '{8'h00, 4'h0, 1'b0, 1'b0};
      tbl[5] = '{8'h01, 4'h0, 1'b1, 1'b0};
      tbl[6] = '{8'hFF, 4'hF, 1'b0, 1'b0};
      tbl[7] = '{8'h7F, 4'hF, 1'b1, 1'b0};
      tbl[8] = '{8'hFB, 4'hF, 1'b1, 1'b0};
      tbl[9] = '{8'h3F, 4'h7, 1'b0, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_datos_out", datos_out, 0);
      chk("rst_err_simple", err_simple, 0);
      chk("rst_err_doble", err_doble, 0);
      chk("rst_cnt_corr", cnt_corr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++)
         xfer(tbl[i], 0, 1'b0, 1'b0);

      xfer(tbl[0], 10, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("no_capture_pulse", out_valid, 0);
      end

      xfer(tbl[1], 0, 1'b0, 1'b1);
      xfer(tbl[1], 2, 1'b0, 1'b0);

      datos_cod = 8'h56;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      exp_corr  = 0;
      exp_doble = 0;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_in_ready", in_ready, 1);
      chk("rst_mid_cnt_corr", cnt_corr, exp_corr);
      chk("rst_mid_cnt_doble", cnt_doble, exp_doble);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("rst_no_output", out_valid, 0);
      end

      xfer(tbl[3], 0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
